sr_latch_ctrl: RTL and testbench

Arbitrated sequencer that drives the s/r inputs of one sr_latch on behalf of N requesters. Each requester asks for a set or a clear. A round-robin arbiter picks one request. The controller then issues a clean s or r pulse of fixed width, followed by a guard gap with both inputs low. It never drives s=r=1, so the latch never enters its forbidden state. Latch output q is fed back, so a request that is already satisfied completes without a pulse.

---
 rtl/sr_latch_ctrl.sv | 122 ++++++++++++
 tb/tb_sr_latch_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl.sv
// rtl/sr_latch_ctrl.sv - round-robin sequencer driving clean s/r pulses into one sr_latch
module sr_latch_ctrl #(
    parameter int N       = 4,
    parameter int PULSE_W = 2,
    parameter int GAP     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] set_req,
    input  logic [N-1:0] clr_req,
    input  logic         q_fb,
    output logic         s,
    output logic         r,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic         done,
    output logic         skipped,
    output logic [N-1:0] conflict
);

    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int MAXC = (PULSE_W > GAP) ? PULSE_W : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP,
        ST_ACK
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          win_found;
    logic [N-1:0]  elig;
    logic [CW-1:0] cnt;

    // A requester asking for both set and clear at once is ignored; only a clean single request competes
    assign elig = set_req ^ clr_req;

    // Round-robin search: first eligible requester after the last winner, wrapping modulo N
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IW'((int'(ptr) + off) % N);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Sequencer: arbitrate in IDLE, pulse s or r, hold a quiet gap, then acknowledge for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= IW'(N - 1);
            cnt      <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            gnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            skipped  <= 1'b0;
            conflict <= '0;
        end else begin
            conflict <= set_req & clr_req;
            done     <= 1'b0;
            skipped  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        ptr  <= win_idx;
                        gnt  <= N'(1) << win_idx;
                        busy <= 1'b1;
                        cnt  <= '0;
                        // Latch already holds the requested value: acknowledge without pulsing
                        if (set_req[win_idx] == q_fb) begin
                            state   <= ST_ACK;
                            done    <= 1'b1;
                            skipped <= 1'b1;
                        end else begin
                            state <= ST_PULSE;
                            s     <= set_req[win_idx];
                            r     <= ~set_req[win_idx];
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt == CW'(PULSE_W - 1)) begin
                        s     <= 1'b0;
                        r     <= 1'b0;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == CW'(GAP - 1)) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ACK: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb/tb_sr_latch_ctrl.sv - randomized self-checking bench for sr_latch_ctrl against a timeline model
module tb_sr_latch_ctrl;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int GP = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] set_req, clr_req;
    logic         q_fb;
    logic         s, r, busy, done, skipped;
    logic [N-1:0] gnt, conflict;

    sr_latch_ctrl #(.N(N), .PULSE_W(PW), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
        .s(s), .r(r), .gnt(gnt), .busy(busy), .done(done), .skipped(skipped),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         s;
        logic         r;
        logic [N-1:0] gnt;
        logic         busy;
        logic         done;
        logic         skipped;
    } out_t;

    out_t         timeline[$];
    int           ptr;
    out_t         exp_o;
    logic [N-1:0] exp_conf;
    int           assertions = 0;
    int           failures   = 0;

    function automatic out_t observed();
        out_t o;
        o = {s, r, gnt, busy, done, skipped};
        return o;
    endfunction

    // Advance one clock; the model decides at the edge what the outputs must be afterwards
    task automatic tick();
        logic [N-1:0] el, g;
        int           w;
        logic         is_set;
        out_t         e;
        @(posedge clk);
        el       = set_req ^ clr_req;
        exp_conf = rst ? '0 : (set_req & clr_req);
        e        = '0;
        w        = -1;
        if (rst) begin
            timeline.delete();
            ptr = N - 1;
        end else if (timeline.size() != 0) begin
            e = timeline.pop_front();
        end else begin
            for (int k = 1; k <= N; k++)
                if (w < 0 && el[(ptr + k) % N]) w = (ptr + k) % N;
            if (w >= 0) begin
                ptr    = w;
                g      = '0;
                g[w]   = 1'b1;
                is_set = set_req[w];
                if (is_set == q_fb) begin
                    timeline.push_back({1'b0, 1'b0, g, 1'b1, 1'b1, 1'b1});
                end else begin
                    for (int k = 0; k < PW; k++) timeline.push_back({is_set, ~is_set, g, 1'b1, 1'b0, 1'b0});
                    for (int k = 0; k < GP; k++) timeline.push_back({1'b0, 1'b0, g, 1'b1, 1'b0, 1'b0});
                    timeline.push_back({1'b0, 1'b0, g, 1'b1, 1'b1, 1'b0});
                end
                timeline.push_back('0);
                e = timeline.pop_front();
            end
        end
        exp_o = e;
        #1;
        if (s) q_fb = 1'b1;
        else if (r) q_fb = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_req = 4'b1111;
        clr_req = 4'b0110;
        q_fb    = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        assertions++;
        if (observed() !== out_t'(0) || conflict !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b conf=%b, want all zero", observed(), conflict);
        end
        rst     = 1'b0;
        clr_req = 4'b0000;
        tick();
        assertions++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_priority: gnt=%b want 0001", gnt);
        end
        set_req = '0;
        for (int c = 0; c < 8; c++) tick();
    endtask

    task automatic test_single_set();
        out_t want;
        apply_reset();
        q_fb    = 1'b0;
        set_req = 4'b0001;
        clr_req = 4'b0000;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) set_req = 4'b0000;
            want = {(c == 1 || c == 2), 1'b0, (c <= 4) ? 4'b0001 : 4'b0000, (c <= 4), (c == 4), 1'b0};
            assertions++;
            if (observed() !== want) begin
                failures++;
                $display("FAIL single_set cycle %0d: got %b want %b", c + 1, observed(), want);
            end
            assertions++;
            if (observed() !== exp_o) begin
                failures++;
                $display("FAIL single_set_model cycle %0d: got %b want %b", c + 1, observed(), exp_o);
            end
        end
    endtask

    task automatic test_round_robin();
        int           order[$];
        int           want_order[4];
        logic [N-1:0] prev_gnt;
        want_order = '{0, 1, 2, 0};
        apply_reset();
        q_fb     = 1'b0;
        set_req  = 4'b0101;
        clr_req  = 4'b0010;
        prev_gnt = '0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            tick();
            if (prev_gnt == '0 && gnt != '0) order.push_back($clog2(gnt));
            prev_gnt = gnt;
            assertions++;
            if (observed() !== exp_o || (s && r)) begin
                failures++;
                $display("FAIL rr_model: got %b want %b", observed(), exp_o);
            end
        end
        assertions++;
        if (order.size() != 4) begin
            failures++;
            $display("FAIL rr_count: got %0d grants want 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                assertions++;
                if (order[i] != want_order[i]) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], want_order[i]);
                end
            end
        end
        set_req = '0;
        clr_req = '0;
        for (int c = 0; c < 8; c++) tick();
    endtask

    task automatic test_skip();
        apply_reset();
        q_fb    = 1'b1;
        set_req = 4'b1000;
        clr_req = 4'b0000;
        tick();
        set_req = 4'b0000;
        assertions++;
        if (gnt !== 4'b1000 || done !== 1'b1 || skipped !== 1'b1 || s !== 1'b0) begin
            failures++;
            $display("FAIL skip: gnt=%b done=%b skipped=%b s=%b want 1000 1 1 0", gnt, done, skipped, s);
        end
        tick();
        assertions++;
        if (gnt !== 4'b0000 || done !== 1'b0 || observed() !== exp_o) begin
            failures++;
            $display("FAIL skip_release: got %b want %b", observed(), exp_o);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        q_fb    = 1'b0;
        set_req = 4'b0011;
        clr_req = 4'b0010;
        tick();
        assertions++;
        if (conflict !== 4'b0010 || gnt !== 4'b0001) begin
            failures++;
            $display("FAIL conflict: conf=%b gnt=%b want 0010 0001", conflict, gnt);
        end
        for (int c = 0; c < 14; c++) begin
            tick();
            assertions++;
            if (gnt[1] !== 1'b0 || conflict !== exp_conf || observed() !== exp_o) begin
                failures++;
                $display("FAIL conflict_hold: got %b conf=%b want %b conf=%b", observed(), conflict, exp_o, exp_conf);
            end
        end
        set_req = '0;
        clr_req = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        q_fb    = 1'b0;
        set_req = 4'b0100;
        clr_req = 4'b0000;
        tick();
        tick();
        assertions++;
        if (s !== 1'b1 || gnt !== 4'b0100) begin
            failures++;
            $display("FAIL mid_pulse_start: s=%b gnt=%b want 1 0100", s, gnt);
        end
        rst = 1'b1;
        tick();
        assertions++;
        if (s !== 1'b0 || gnt !== 4'b0000 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: s=%b gnt=%b done=%b want 0 0000 0", s, gnt, done);
        end
        rst     = 1'b0;
        set_req = 4'b0101;
        tick();
        assertions++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL mid_restart: gnt=%b want 0001", gnt);
        end
        set_req = '0;
        for (int c = 0; c < 8; c++) tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) begin
                set_req = N'($urandom);
                clr_req = N'($urandom) & N'($urandom);
            end
            if ($urandom_range(15) == 0) q_fb = ~q_fb;
            tick();
            assertions++;
            if (observed() !== exp_o || conflict !== exp_conf || (s && r)) begin
                failures++;
                $display("FAIL random cycle %0d: got %b conf=%b want %b conf=%b", c, observed(), conflict, exp_o, exp_conf);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        set_req = '0;
        clr_req = '0;
        q_fb    = 1'b0;
        ptr     = N - 1;
        test_reset();
        test_single_set();
        test_round_robin();
        test_skip();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
